// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes, FSM states
// and the parity helper.
package uart_tx_buffered_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Payload is zero-extended to 8 bits by the caller; zero padding leaves XOR unchanged.
    function automatic logic parity_bit(input int mode, input logic [7:0] data);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// Writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a FIFO; queued words go out as back-to-back frames.
//   state     | meaning
//   ST_IDLE   | line high, waiting for a buffered word
//   ST_START  | start bit (0)
//   ST_DATA   | DATA_BITS payload bits, LSB first
//   ST_PARITY | parity bit (only when PARITY != none)
//   ST_STOP   | STOP_BITS stop bits (1); pops the next word on the last one
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLOCK      = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CLKS_PER_BIT = CLOCK / BAUD;
    localparam int DIV_W        = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    state_t               state;
    logic [DIV_W-1:0]     div;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 last_stop;

    assign s_ready   = rstn & ~fifo_full;
    assign push      = s_valid & s_ready;
    assign bit_end   = (div == DIV_LAST);
    assign last_stop = (state == ST_STOP) && bit_end && (bit_cnt == 4'(STOP_BITS - 1));
    assign pop       = ~fifo_empty && ((state == ST_IDLE) || last_stop);
    assign busy      = (state != ST_IDLE) | ~fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (push),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else if (pop) begin
            // Word is latched here; the FIFO head is never re-read mid-frame.
            state   <= ST_START;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= head;
            par     <= parity_bit(PARITY, 8'(head));
            tx      <= 1'b0;
        end else if (state != ST_IDLE) begin
            if (!bit_end) begin
                div <= div + DIV_W'(1);
            end else begin
                div <= '0;
                case (state)
                    ST_START: begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx    <= par;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (last_stop) begin
                            tx    <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        tx    <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: four configurations at 10 clk/bit, table-driven frames,
// a scoreboard-fed line monitor on the 8N1 instance, and hand-timed FIFO/reset sequences.
module tb_uart_tx_buffered;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [7:0] d_a, d_e, d_o;
    logic [6:0] d_s;
    logic       v_a, v_e, v_o, v_s;
    logic       r_a, r_e, r_o, r_s;
    logic       tx_a, tx_e, tx_o, tx_s;
    logic       busy_a, busy_e, busy_o, busy_s;
    logic [2:0] lvl_a, lvl_e, lvl_o, lvl_s;

    uart_tx_buffered #(.CLOCK(100000000), .BAUD(10000000), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rstn(rstn), .s_data(d_a), .s_valid(v_a), .s_ready(r_a),
        .tx(tx_a), .busy(busy_a), .fifo_level(lvl_a));
    uart_tx_buffered #(.CLOCK(100000000), .BAUD(10000000), .PARITY(2), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .rstn(rstn), .s_data(d_e), .s_valid(v_e), .s_ready(r_e),
        .tx(tx_e), .busy(busy_e), .fifo_level(lvl_e));
    uart_tx_buffered #(.CLOCK(100000000), .BAUD(10000000), .PARITY(1), .FIFO_DEPTH(4)) u_o (
        .clk(clk), .rstn(rstn), .s_data(d_o), .s_valid(v_o), .s_ready(r_o),
        .tx(tx_o), .busy(busy_o), .fifo_level(lvl_o));
    uart_tx_buffered #(.CLOCK(100000000), .BAUD(10000000), .DATA_BITS(7), .STOP_BITS(2),
                       .FIFO_DEPTH(4)) u_s (
        .clk(clk), .rstn(rstn), .s_data(d_s), .s_valid(v_s), .s_ready(r_s),
        .tx(tx_s), .busy(busy_s), .fifo_level(lvl_s));

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         nbits;
        logic [11:0] line;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0: return tx_a;
            1: return tx_e;
            2: return tx_o;
            default: return tx_s;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_e;
            2: return busy_o;
            default: return busy_s;
        endcase
    endfunction

    function automatic logic get_rdy(input int sel);
        case (sel)
            0: return r_a;
            1: return r_e;
            2: return r_o;
            default: return r_s;
        endcase
    endfunction

    function automatic logic [2:0] get_lvl(input int sel);
        case (sel)
            0: return lvl_a;
            1: return lvl_e;
            2: return lvl_o;
            default: return lvl_s;
        endcase
    endfunction

    task automatic drive(input int sel, input logic [7:0] data, input logic valid);
        case (sel)
            0: begin d_a = data;      v_a = valid; end
            1: begin d_e = data;      v_e = valid; end
            2: begin d_o = data;      v_o = valid; end
            default: begin d_s = data[6:0]; v_s = valid; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One push into an idle instance, then the line is compared every cycle.
    task automatic run_vec(input vec_t v);
        int mism;
        logic [11:0] got;
        mism = 0;
        got  = '0;
        drive(v.sel, v.data, 1'b1);
        if (v.sel == 0) sb_q.push_back(v.data);
        step();
        drive(v.sel, v.data, 1'b0);
        check("tx_high_on_push_edge", get_tx(v.sel), 1'b1);
        for (int c = 0; c < v.nbits * 10; c++) begin
            step();
            if (get_tx(v.sel) !== v.line[c / 10]) mism++;
            if (c % 10 == 5) got[c / 10] = get_tx(v.sel);
        end
        check("frame_bits", got, v.line);
        check("frame_bit_timing_errs", mism, 0);
        check("busy_before_last_edge", get_busy(v.sel), 1'b1);
        step();
        check("busy_after_frame", get_busy(v.sel), 1'b0);
        check("tx_idle_after_frame", get_tx(v.sel), 1'b1);
    endtask

    task automatic mon_check(input logic [9:0] f);
        logic [7:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_frame: got %0h expected none at %0t", f, $time);
        end else begin
            exp = sb_q.pop_front();
            check("sb_frame", f, {1'b1, exp, 1'b0});
        end
    endtask

    // Frame decoder on the 8N1 instance: mid-bit samples, compared against the scoreboard.
    logic       tx_prev = 1'b1;
    logic       mon_on  = 1'b0;
    int         mon_cnt = 0;
    logic [8:0] mon_bits = '0;

    always @(negedge clk) begin
        tx_prev <= tx_a;
        if (!rstn) begin
            mon_on <= 1'b0;
        end else if (!mon_on) begin
            if (tx_prev && !tx_a) begin
                mon_on  <= 1'b1;
                mon_cnt <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if ((mon_cnt % 10 == 5) && (mon_cnt < 95)) mon_bits[mon_cnt / 10] <= tx_a;
            if (mon_cnt == 95) begin
                mon_on <= 1'b0;
                mon_check({tx_a, mon_bits});
            end
        end
    end

    initial begin
        int n;
        vecs[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
        vecs[1] = '{0, 8'h00, 10, {2'b00, 1'b1, 8'h00, 1'b0}};
        vecs[2] = '{0, 8'hFF, 10, {2'b00, 1'b1, 8'hFF, 1'b0}};
        vecs[3] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}};
        vecs[4] = '{2, 8'h07, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
        vecs[5] = '{1, 8'h81, 11, {1'b0, 1'b1, 1'b0, 8'h81, 1'b0}};
        vecs[6] = '{2, 8'h00, 11, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}};
        vecs[7] = '{3, 8'h7F, 10, {2'b00, 2'b11, 7'h7F, 1'b0}};
        vecs[8] = '{3, 8'h2A, 10, {2'b00, 2'b11, 7'h2A, 1'b0}};

        rstn = 1'b0;
        for (int s = 0; s < 4; s++) drive(s, 8'h00, 1'b0);
        repeat (3) step();
        for (int s = 0; s < 4; s++) begin
            check("rst_tx", get_tx(s), 1'b1);
            check("rst_busy", get_busy(s), 1'b0);
            check("rst_level", get_lvl(s), 3'd0);
            check("rst_ready_held", get_rdy(s), 1'b0);
        end
        rstn = 1'b1;
        #1;
        check("ready_after_release", r_a, 1'b1);
        step();

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
            repeat (3) step();
        end

        // Six consecutive pushes into an idle 4-deep FIFO.
        for (int k = 0; k < 6; k++) begin
            d_a = 8'h10 + 8'(k);
            v_a = 1'b1;
            check("fill_ready", r_a, (k < 5) ? 1'b1 : 1'b0);
            if (k < 5) sb_q.push_back(d_a);
            step();
        end
        v_a = 1'b0;
        check("fill_level", lvl_a, 3'd4);
        n = 0;
        while (busy_a && n < 700) begin
            step();
            n++;
        end
        check("b2b_span_cycles", n, 496);
        repeat (3) step();

        // Same-edge push+pop at full and at level 2.
        for (int k = 0; k < 5; k++) begin
            d_a = 8'h30 + 8'(k);
            v_a = 1'b1;
            sb_q.push_back(d_a);
            step();
        end
        d_a = 8'hEE;
        check("full_level", lvl_a, 3'd4);
        check("full_ready", r_a, 1'b0);
        repeat (96) step();
        check("full_hold_level", lvl_a, 3'd4);
        step();
        v_a = 1'b0;
        check("pushpop_full_level", lvl_a, 3'd3);
        repeat (199) step();
        check("pre_pushpop_mid_level", lvl_a, 3'd2);
        d_a = 8'h5A;
        v_a = 1'b1;
        sb_q.push_back(d_a);
        step();
        v_a = 1'b0;
        check("pushpop_mid_level", lvl_a, 3'd2);
        n = 0;
        while (busy_a && n < 700) begin
            step();
            n++;
        end
        check("pushpop_drain_cycles", n, 300);
        repeat (3) step();

        // Reset during data bit 3 with two words still queued.
        for (int k = 0; k < 3; k++) begin
            d_a = (k == 0) ? 8'hF7 : 8'h11 + 8'(k);
            v_a = 1'b1;
            step();
        end
        v_a = 1'b0;
        repeat (43) step();
        check("pre_reset_bit3", tx_a, 1'b0);
        check("pre_reset_level", lvl_a, 3'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("midframe_rst_tx", tx_a, 1'b1);
        check("midframe_rst_level", lvl_a, 3'd0);
        check("midframe_rst_busy", busy_a, 1'b0);
        repeat (3) step();
        rstn = 1'b1;
        step();
        run_vec('{0, 8'h55, 10, {2'b00, 1'b1, 8'h55, 1'b0}});

        repeat (5) step();
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
